// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one registered AND/OR/NAND/XOR unit
// among NUM_REQ requesters, with a tagged valid/ready response channel.
//
// Ports:
//   clk, rst_n        rising-edge clock, async active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_op/a/b        packed per-requester opcode and operands
//   rsp_valid/ready   response handshake
//   rsp_id, rsp_data  owning requester and bitwise result
//   busy              high whenever an operation is in flight
module logic_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     owner;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;

    logic [ID_W-1:0]     winner;
    logic                found;
    logic [ID_W:0]       sum;
    logic [ID_W-1:0]     idx;
    logic [DATA_W-1:0]   result;

    logic [1:0]          op_arr [NUM_REQ];
    logic [DATA_W-1:0]   a_arr  [NUM_REQ];
    logic [DATA_W-1:0]   b_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[2*i +: 2];
        assign a_arr[i]  = req_a[DATA_W*i +: DATA_W];
        assign b_arr[i]  = req_b[DATA_W*i +: DATA_W];
    end

    // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant is combinational so the winner sees ready in its accept cycle;
    // gated by rst_n so no requester is accepted while held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        result = '0;
        case (op_q)
            2'b00:   result = a_q & b_q;
            2'b01:   result = a_q | b_q;
            2'b10:   result = ~(a_q & b_q);
            default: result = a_q ^ b_q;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        op_q  <= op_arr[winner];
                        a_q   <= a_arr[winner];
                        b_q   <= b_arr[winner];
                        owner <= winner;
                        if (winner == ID_W'(NUM_REQ-1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= winner + 1'b1;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= result;
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Testbench for logic_op_scheduler: cycle model plus directed
// scenarios with literal expectations for grants and results.
module tb_logic_op_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_data;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int data;
        int cyc;
    } ev_t;

    ev_t gnt_q[$];
    ev_t rsp_q[$];

    // Model: phase 0 waiting, 1 computing, 2 offering response.
    int         m_phase = 0;
    int         m_ptr = 0;
    int         m_id = 0;
    logic [W-1:0] m_data = '0;

    logic [W-1:0] exp2 [4] = '{8'h30, 8'hFC, 8'hCF, 8'hCC};

    always #5 clk = ~clk;

    logic_op_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] opres(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] win_res(input int w);
        return opres(req_op[2*w +: 2], req_a[W*w +: W], req_b[W*w +: W]);
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r = '0;
        if (rst_n && m_phase == 0 && req_valid != 0) begin
            r[pick(m_ptr, req_valid)] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ptr   <= 0;
        end else begin
            case (m_phase)
                0: if (req_valid != 0) begin
                    m_id    <= pick(m_ptr, req_valid);
                    m_data  <= win_res(pick(m_ptr, req_valid));
                    m_ptr   <= (pick(m_ptr, req_valid) + 1) % N;
                    m_phase <= 1;
                end
                1: m_phase <= 2;
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("req_ready", req_ready, exp_ready());
        chk("rsp_valid", rsp_valid, rst_n && m_phase == 2);
        chk("busy", busy, rst_n && m_phase != 0);
        if (rst_n && m_phase == 2) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
        end
        if (req_ready != 0) begin
            gnt_q.push_back('{$clog2(req_ready), 0, cyc});
        end
        if (rsp_valid && rsp_ready) begin
            rsp_q.push_back('{int'(rsp_id), int'(rsp_data), cyc});
        end
    end

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[2*i +: 2] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic wait_gnt(input int n, input string nm);
        int t = 0;
        while (gnt_q.size() < n && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(nm, gnt_q.size() >= n, 1);
    endtask

    task automatic wait_rsp(input int n, input string nm);
        int t = 0;
        while (rsp_q.size() < n && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(nm, rsp_q.size() >= n, 1);
    endtask

    task automatic wait_valid(input string nm);
        int t = 0;
        while (rsp_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(nm, rsp_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (5) @(negedge clk);
        #1;
        chk("idle_no_grants", gnt_q.size(), 0);

        // Requester 0 alone, all four opcodes.
        for (int k = 0; k < 4; k++) begin
            int g;
            int r;
            @(posedge clk);
            #1;
            g = gnt_q.size();
            r = rsp_q.size();
            set_req(0, k[1:0], 8'hF0, 8'h3C);
            req_valid[0] = 1'b1;
            rsp_ready = 1'b1;
            wait_gnt(g + 1, "op_grant_timeout");
            @(posedge clk);
            #1 req_valid[0] = 1'b0;
            wait_rsp(r + 1, "op_rsp_timeout");
            if (rsp_q.size() > r && gnt_q.size() > g) begin
                chk("op_data", rsp_q[r].data, exp2[k]);
                chk("op_id", rsp_q[r].id, 0);
                chk("op_latency", rsp_q[r].cyc - gnt_q[g].cyc, 2);
            end
        end

        // All four requesters valid from reset.
        @(posedge clk);
        #1 rst_n = 1'b0;
        gnt_q.delete();
        rsp_q.delete();
        for (int i = 0; i < N; i++) set_req(i, i[1:0], 8'hF0, 8'h3C);
        req_valid = '1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_gnt(5, "rr_grant_timeout");
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(5, "rr_rsp_timeout");
        for (int i = 0; i < 5 && i < gnt_q.size(); i++) begin
            chk("rr_order", gnt_q[i].id, i % N);
        end
        for (int i = 0; i < 4 && i + 1 < gnt_q.size(); i++) begin
            chk("rr_spacing", gnt_q[i+1].cyc - gnt_q[i].cyc, 3);
        end
        for (int i = 0; i < 5 && i < rsp_q.size() && i < gnt_q.size(); i++) begin
            chk("rr_rsp_id", rsp_q[i].id, gnt_q[i].id);
        end
        for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
            chk("rr_rsp_data", rsp_q[i].data, exp2[i]);
        end
        chk("model_ptr", m_ptr, 1);

        // Requester 2 with response backpressure; 1 waits meanwhile.
        @(posedge clk);
        #1;
        gnt_q.delete();
        rsp_q.delete();
        set_req(2, 2'b01, 8'hAA, 8'h55);
        req_valid[2] = 1'b1;
        rsp_ready = 1'b0;
        wait_gnt(1, "bp_grant_timeout");
        if (gnt_q.size() > 0) chk("bp_grant_id", gnt_q[0].id, 2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        set_req(1, 2'b11, 8'h0F, 8'hFF);
        req_valid[1] = 1'b1;
        wait_valid("bp_valid_timeout");
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 8'hFF);
            chk("bp_id", rsp_id, 2);
            chk("bp_no_ready", req_ready, 0);
            @(negedge clk);
            #1;
        end
        chk("bp_one_grant", gnt_q.size(), 1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_gnt(2, "bp_next_timeout");
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(2, "bp_rsp_timeout");
        if (rsp_q.size() > 1 && gnt_q.size() > 1) begin
            chk("bp_rsp_data", rsp_q[0].data, 8'hFF);
            chk("bp_rsp_id", rsp_q[0].id, 2);
            chk("bp_next_id", gnt_q[1].id, 1);
            chk("bp_next_cyc", gnt_q[1].cyc - rsp_q[0].cyc, 1);
            chk("bp_next_data", rsp_q[1].data, 8'hF0);
        end

        // Pointer at 2: requesters 3 then 1, then 0 alone.
        @(posedge clk);
        #1;
        gnt_q.delete();
        rsp_q.delete();
        set_req(1, 2'b00, 8'hF0, 8'h3C);
        set_req(3, 2'b10, 8'hFF, 8'h0F);
        req_valid = 4'b1010;
        wait_gnt(1, "wrap_g1_timeout");
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        wait_gnt(2, "wrap_g2_timeout");
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        set_req(0, 2'b11, 8'hAA, 8'hFF);
        req_valid[0] = 1'b1;
        wait_gnt(3, "wrap_g3_timeout");
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(3, "wrap_rsp_timeout");
        if (gnt_q.size() > 2 && rsp_q.size() > 2) begin
            chk("wrap_first", gnt_q[0].id, 3);
            chk("wrap_second", gnt_q[1].id, 1);
            chk("wrap_third", gnt_q[2].id, 0);
            chk("wrap_gap", gnt_q[2].cyc - gnt_q[1].cyc, 3);
            chk("wrap_nand", rsp_q[0].data, 8'hF0);
            chk("wrap_xor", rsp_q[2].data, 8'h55);
        end

        // Reset while a response is pending.
        @(posedge clk);
        #1;
        gnt_q.delete();
        rsp_q.delete();
        set_req(0, 2'b00, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        wait_gnt(1, "rst_grant_timeout");
        @(posedge clk);
        #1 req_valid = '0;
        wait_valid("rst_valid_timeout");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        set_req(1, 2'b01, 8'h12, 8'h30);
        set_req(2, 2'b00, 8'h00, 8'h00);
        req_valid = 4'b0110;
        chk("rst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        wait_gnt(2, "rst_regrant_timeout");
        chk("rst_no_rsp", rsp_q.size(), 0);
        if (gnt_q.size() > 1) chk("rst_first_id", gnt_q[1].id, 1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(1, "rst_rsp_timeout");
        if (rsp_q.size() > 0) begin
            chk("rst_rsp_id", rsp_q[0].id, 1);
            chk("rst_rsp_data", rsp_q[0].data, 8'h32);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_op_scheduler.md
Name: logic_op_scheduler

Overview:
- Round-robin scheduler that shares one registered logic-op datapath (AND/OR/NAND/XOR on DATA_W-bit operands) among NUM_REQ requesters.
- Each requester presents an opcode and two operands with a valid/ready handshake.
- The scheduler grants one requester, sequences the datapath through an execute cycle, and returns the tagged result on a single valid/ready response channel.
- Sits between client blocks and the shared logic unit; it serialises access to that unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width in bits.
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived; do not override).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, at most one bit set.
- req_op  input  2*NUM_REQ  opcode, requester i at bits [2i+1:2i]: 00 AND, 01 OR, 10 NAND, 11 XOR.
- req_a  input  DATA_W*NUM_REQ  operand A, requester i at slice i.
- req_b  input  DATA_W*NUM_REQ  operand B, requester i at slice i.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_data  output  DATA_W  bitwise result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Internal operand/op/owner registers are cleared.
- States: IDLE, EXEC, RESP. Transitions occur only on the clk rising edge.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward from rr_ptr with wrap.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits stay 0.
  - On that edge: latch winner's op/a/b and owner id, set rr_ptr=(winner+1) mod NUM_REQ, go to EXEC.
  - If no req_valid is high: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - One cycle, req_ready=0.
  - On the edge, register the result into rsp_data and owner into rsp_id, then go to RESP:
    - AND = a&b
    - OR = a|b
    - NAND = ~(a&b)
    - XOR = a^b
  - All results are full DATA_W bitwise; no carries or truncation.
- RESP:
  - rsp_valid=1; rsp_data/rsp_id held stable until rsp_ready.
  - On the edge where rsp_valid&&rsp_ready: rsp_valid falls and the state returns to IDLE.
  - rsp_data/rsp_id keep their last value; they are don't-care while rsp_valid=0.
  - While rsp_ready=0: remain in RESP indefinitely (backpressure); no new grants.
- Latency:
  - Accept in cycle T gives rsp_valid high in cycle T+2.
  - Response handshake in cycle R allows a new grant in cycle R+1.
  - Minimum issue interval is 3 cycles per operation.
- Requester rules:
  - A requester holds op/a/b stable while req_valid=1 and req_ready=0.
  - Dropping req_valid before grant is legal; the scheduler samples payload only in the grant cycle.
- req_ready is never asserted outside IDLE, and never for a requester whose req_valid=0.
- Simultaneous requests:
  - Exactly one is granted.
  - Losers keep waiting and are served in rotating order.
  - No requester waits more than NUM_REQ-1 other grants.
- Single persistent requester i: granted every issue slot (rr_ptr skips idle requesters).
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response; after release, the next grant starts from requester 0.

Test Plan:
- Reset then release, all req_valid=0 for 5 cycles -> req_ready=0, rsp_valid=0, busy=0 throughout.
- Requester 0: op=00, a=8'hF0, b=8'h3C, accepted in cycle T with rsp_ready=1 -> rsp_valid in T+2, rsp_id=0, rsp_data=8'h30. Repeat with op 01/10/11 -> 8'hFC, 8'hCF, 8'hCC.
- All 4 requesters valid continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0; issue spacing exactly 3 cycles; each rsp_id matches its grant order.
- Requester 2 wins, then rsp_ready held low for 6 cycles with a=8'hAA, b=8'h55, op=01 -> rsp_valid stays high with rsp_data=8'hFF, rsp_id=2; no req_ready asserted; completes the cycle rsp_ready rises.
- Requesters 1 and 3 valid, rr_ptr=2 -> requester 3 granted first, then 1; requester 0 valid alone afterwards -> granted at next IDLE.
- Assert rst_n low during RESP -> rsp_valid=0 immediately (async); after release, requesters 1 and 2 both valid -> requester 1 granted first.
